// File: rtl/demux_router.sv
// demux_router: 2-entry FIFO that steers each tagged word to one of four
// valid/ready output channels in strict arrival order, with per-channel delivery counters.
module demux_router #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [WIDTH-1:0] iData,
  input  logic             iS1,
  input  logic             iS0,
  input  logic             iValid,
  output logic             oReady,
  output logic [WIDTH-1:0] oZ0,
  output logic [WIDTH-1:0] oZ1,
  output logic [WIDTH-1:0] oZ2,
  output logic [WIDTH-1:0] oZ3,
  output logic             oValid0,
  output logic             oValid1,
  output logic             oValid2,
  output logic             oValid3,
  input  logic             iReady0,
  input  logic             iReady1,
  input  logic             iReady2,
  input  logic             iReady3,
  output logic [CNT_W-1:0] oCount0,
  output logic [CNT_W-1:0] oCount1,
  output logic [CNT_W-1:0] oCount2,
  output logic [CNT_W-1:0] oCount3,
  output logic             oBusy
);

  logic [1:0]       memSel  [2];
  logic [WIDTH-1:0] memData [2];
  logic             rdPtr;
  logic             wrPtr;
  logic [1:0]       occ;
  logic [CNT_W-1:0] cnt [4];

  logic [1:0]       headSel;
  logic [WIDTH-1:0] headData;
  logic             headValid;
  logic [3:0]       readyVec;
  logic [3:0]       validVec;
  logic             push;
  logic             pop;

  assign headSel   = memSel[rdPtr];
  assign headData  = memData[rdPtr];
  assign headValid = (occ != 2'd0);
  assign readyVec  = {iReady3, iReady2, iReady1, iReady0};

  // Ready looks only at occupancy, so consumers never see a ready-to-ready path.
  assign oReady = (occ != 2'd2) && !iRst;
  assign push   = iValid && oReady;
  assign pop    = headValid && readyVec[headSel];

  always_comb begin
    validVec = 4'b0000;
    if (headValid) begin
      validVec[headSel] = 1'b1;
    end
  end

  // Payload storage needs no reset; occupancy gates everything that leaves the block.
  always_ff @(posedge iClk) begin
    if (push) begin
      memSel[wrPtr]  <= {iS1, iS0};
      memData[wrPtr] <= iData;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      rdPtr <= 1'b0;
      wrPtr <= 1'b0;
      occ   <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      if (push) begin
        wrPtr <= ~wrPtr;
      end
      if (pop) begin
        rdPtr        <= ~rdPtr;
        cnt[headSel] <= cnt[headSel] + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign oValid0 = validVec[0];
  assign oValid1 = validVec[1];
  assign oValid2 = validVec[2];
  assign oValid3 = validVec[3];

  assign oZ0 = validVec[0] ? headData : '0;
  assign oZ1 = validVec[1] ? headData : '0;
  assign oZ2 = validVec[2] ? headData : '0;
  assign oZ3 = validVec[3] ? headData : '0;

  assign oCount0 = cnt[0];
  assign oCount1 = cnt[1];
  assign oCount2 = cnt[2];
  assign oCount3 = cnt[3];

  assign oBusy = headValid;

endmodule

// File: tb/tb_demux_router.sv
// Bench for demux_router: directed vector table, hand-written corner sequences,
// and random traffic checked against a queue-based model of the router.
module tb_demux_router;
  localparam int WIDTH = 32;
  localparam int CNT_W = 8;

  logic             iClk = 1'b0;
  logic             iRst;
  logic [WIDTH-1:0] iData;
  logic             iS1, iS0, iValid;
  logic             oReady;
  logic [WIDTH-1:0] oZ0, oZ1, oZ2, oZ3;
  logic             oValid0, oValid1, oValid2, oValid3;
  logic             iReady0, iReady1, iReady2, iReady3;
  logic [CNT_W-1:0] oCount0, oCount1, oCount2, oCount3;
  logic             oBusy;

  always #5 iClk = ~iClk;

  demux_router #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .iClk(iClk), .iRst(iRst), .iData(iData), .iS1(iS1), .iS0(iS0),
    .iValid(iValid), .oReady(oReady),
    .oZ0(oZ0), .oZ1(oZ1), .oZ2(oZ2), .oZ3(oZ3),
    .oValid0(oValid0), .oValid1(oValid1), .oValid2(oValid2), .oValid3(oValid3),
    .iReady0(iReady0), .iReady1(iReady1), .iReady2(iReady2), .iReady3(iReady3),
    .oCount0(oCount0), .oCount1(oCount1), .oCount2(oCount2), .oCount3(oCount3),
    .oBusy(oBusy)
  );

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] data;
  } entry_t;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [1:0]  sel;
    logic [31:0] data;
    logic [3:0]  rdy;
    logic [3:0]  expV;
    logic [31:0] expD;
    logic        expRdy;
    logic        expBusy;
    logic [31:0] expCnt;
  } vec_t;

  entry_t     mQ[$];
  logic [7:0] mCnt [4];
  vec_t       tbl [12];
  int         vecCount = 0;
  int         errCount = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vecCount++;
    if (act !== exp) begin
      errCount++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle, clock it, and advance the model by the same handshakes.
  task automatic applyCycle(input logic rst, input logic valid, input logic [1:0] sel,
                            input logic [31:0] data, input logic [3:0] rdy);
    logic   doPush, doPop;
    entry_t e;
    iRst   = rst;
    iValid = valid;
    {iS1, iS0} = sel;
    iData  = data;
    {iReady3, iReady2, iReady1, iReady0} = rdy;
    doPush = valid && (mQ.size() < 2) && !rst;
    doPop  = (mQ.size() > 0) && rdy[mQ[0].sel] && !rst;
    @(posedge iClk);
    #1;
    if (rst) begin
      mQ.delete();
      for (int i = 0; i < 4; i++) mCnt[i] = 8'd0;
    end else begin
      if (doPop) begin
        mCnt[mQ[0].sel] = mCnt[mQ[0].sel] + 8'd1;
        void'(mQ.pop_front());
      end
      if (doPush) begin
        e.sel  = sel;
        e.data = data;
        mQ.push_back(e);
      end
    end
  endtask

  task automatic checkModel(input string tag);
    logic [3:0]   expV;
    logic [127:0] expZ;
    expV = 4'b0000;
    expZ = '0;
    if (mQ.size() > 0) begin
      expV[mQ[0].sel] = 1'b1;
      expZ[mQ[0].sel*32 +: 32] = mQ[0].data;
    end
    chk({tag, " valid"}, {124'd0, oValid3, oValid2, oValid1, oValid0}, {124'd0, expV});
    chk({tag, " data"}, {oZ3, oZ2, oZ1, oZ0}, expZ);
    chk({tag, " ready"}, {127'd0, oReady}, {127'd0, (mQ.size() < 2) && !iRst});
    chk({tag, " busy"}, {127'd0, oBusy}, {127'd0, mQ.size() != 0});
    chk({tag, " count"}, {96'd0, oCount3, oCount2, oCount1, oCount0},
        {96'd0, mCnt[3], mCnt[2], mCnt[1], mCnt[0]});
  endtask

  initial begin
    logic [127:0] expZ;

    tbl[0]  = '{1'b1, 1'b0, 2'd0, 32'h0,         4'b0000, 4'b0000, 32'h0,         1'b0, 1'b0, 32'h0000_0000};
    tbl[1]  = '{1'b0, 1'b1, 2'd2, 32'h1111_1111, 4'b0100, 4'b0100, 32'h1111_1111, 1'b1, 1'b1, 32'h0000_0000};
    tbl[2]  = '{1'b0, 1'b0, 2'd0, 32'h0,         4'b0100, 4'b0000, 32'h0,         1'b1, 1'b0, 32'h0001_0000};
    tbl[3]  = '{1'b0, 1'b1, 2'd0, 32'hA,         4'b0000, 4'b0001, 32'hA,         1'b1, 1'b1, 32'h0001_0000};
    tbl[4]  = '{1'b0, 1'b1, 2'd3, 32'hB,         4'b0000, 4'b0001, 32'hA,         1'b0, 1'b1, 32'h0001_0000};
    tbl[5]  = '{1'b0, 1'b1, 2'd1, 32'hC,         4'b0000, 4'b0001, 32'hA,         1'b0, 1'b1, 32'h0001_0000};
    tbl[6]  = '{1'b0, 1'b0, 2'd0, 32'h0,         4'b0000, 4'b0001, 32'hA,         1'b0, 1'b1, 32'h0001_0000};
    tbl[7]  = '{1'b0, 1'b0, 2'd0, 32'h0,         4'b0000, 4'b0001, 32'hA,         1'b0, 1'b1, 32'h0001_0000};
    tbl[8]  = '{1'b0, 1'b0, 2'd0, 32'h0,         4'b0000, 4'b0001, 32'hA,         1'b0, 1'b1, 32'h0001_0000};
    tbl[9]  = '{1'b0, 1'b0, 2'd0, 32'h0,         4'b1000, 4'b0001, 32'hA,         1'b0, 1'b1, 32'h0001_0000};
    tbl[10] = '{1'b0, 1'b0, 2'd0, 32'h0,         4'b0001, 4'b1000, 32'hB,         1'b1, 1'b1, 32'h0001_0001};
    tbl[11] = '{1'b0, 1'b0, 2'd0, 32'h0,         4'b1000, 4'b0000, 32'h0,         1'b1, 1'b0, 32'h0101_0001};

    for (int i = 0; i < 4; i++) mCnt[i] = 8'd0;

    // Reset, then ready must rise as soon as reset is released.
    applyCycle(1'b1, 1'b0, 2'd0, 32'h0, 4'b0000);
    checkModel("reset");
    iRst = 1'b0;
    #1;
    chk("ready after reset", {127'd0, oReady}, {127'd0, 1'b1});

    for (int i = 0; i < 12; i++) begin
      applyCycle(tbl[i].rst, tbl[i].valid, tbl[i].sel, tbl[i].data, tbl[i].rdy);
      expZ = '0;
      for (int n = 0; n < 4; n++) if (tbl[i].expV[n]) expZ[n*32 +: 32] = tbl[i].expD;
      chk($sformatf("tbl%0d valid", i), {124'd0, oValid3, oValid2, oValid1, oValid0}, {124'd0, tbl[i].expV});
      chk($sformatf("tbl%0d data", i), {oZ3, oZ2, oZ1, oZ0}, expZ);
      chk($sformatf("tbl%0d ready", i), {127'd0, oReady}, {127'd0, tbl[i].expRdy});
      chk($sformatf("tbl%0d busy", i), {127'd0, oBusy}, {127'd0, tbl[i].expBusy});
      chk($sformatf("tbl%0d count", i), {96'd0, oCount3, oCount2, oCount1, oCount0}, {96'd0, tbl[i].expCnt});
    end

    // Head-of-line: ch0 word stalls the ch1 word behind it.
    applyCycle(1'b1, 1'b0, 2'd0, 32'h0, 4'b0000);
    applyCycle(1'b0, 1'b1, 2'd0, 32'hA, 4'b0010);
    applyCycle(1'b0, 1'b1, 2'd1, 32'hB, 4'b0010);
    for (int k = 0; k < 3; k++) begin
      applyCycle(1'b0, 1'b0, 2'd0, 32'h0, 4'b0010);
      chk("hol ch1 blocked", {127'd0, oValid1}, {127'd0, 1'b0});
      checkModel("hol stall");
    end
    applyCycle(1'b0, 1'b0, 2'd0, 32'h0, 4'b0011);
    chk("hol ch0 count", {120'd0, oCount0}, {120'd0, 8'd1});
    chk("hol ch1 next", {95'd0, oValid1, oZ1}, {95'd0, 1'b1, 32'hB});
    applyCycle(1'b0, 1'b0, 2'd0, 32'h0, 4'b0011);
    chk("hol ch1 count", {120'd0, oCount1}, {120'd0, 8'd1});
    checkModel("hol done");

    // Streaming 300 words to ch3, one per cycle, counter wraps to 44.
    applyCycle(1'b1, 1'b0, 2'd0, 32'h0, 4'b0000);
    for (int k = 0; k <= 300; k++) begin
      applyCycle(1'b0, k < 300, 2'd3, 32'h5000_0000 + k, 4'b1000);
      if (k < 300) chk("stream word", {95'd0, oValid3, oZ3}, {95'd0, 1'b1, 32'h5000_0000 + k});
      checkModel("stream");
    end
    chk("stream count", {120'd0, oCount3}, {120'd0, 8'd44});

    // Reset with two words stored discards both; next push delivers normally.
    applyCycle(1'b0, 1'b1, 2'd2, 32'h0000_00E1, 4'b0000);
    applyCycle(1'b0, 1'b1, 2'd0, 32'h0000_00E2, 4'b0000);
    chk("full before reset", {126'd0, oReady, oBusy}, {126'd0, 1'b0, 1'b1});
    applyCycle(1'b1, 1'b1, 2'd1, 32'h0000_00E3, 4'b1111);
    checkModel("mid reset");
    applyCycle(1'b0, 1'b0, 2'd0, 32'h0, 4'b1111);
    chk("no delivery after reset", {124'd0, oValid3, oValid2, oValid1, oValid0}, 128'd0);
    applyCycle(1'b0, 1'b1, 2'd1, 32'h0000_D00D, 4'b0000);
    chk("post reset push", {95'd0, oValid1, oZ1}, {95'd0, 1'b1, 32'h0000_D00D});
    applyCycle(1'b0, 1'b0, 2'd0, 32'h0, 4'b0010);
    chk("post reset count", {96'd0, oCount3, oCount2, oCount1, oCount0}, {96'd0, 32'h0000_0100});
    checkModel("post reset");

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      applyCycle($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                 2'($urandom_range(0, 3)), $urandom, 4'($urandom | $urandom));
      checkModel("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule

// File: doc/demux_router.md
Name: demux_router

Overview:
- Inverse of the 4:1 select mux: takes one WIDTH-bit stream, tags each word with a 2-bit destination ({iS1,iS0}) and delivers it to one of four output channels.
- Used in the 3-level storage path to steer lower-level responses to four consumers over valid/ready handshakes.
- A 2-entry FIFO decouples input from output; delivery is strictly in order; per-channel delivery counters support debug and verification.

Parameters:
- WIDTH, 32, data width of input and each output channel.
- CNT_W, 8, width of each per-channel delivery counter.

Ports:
- iClk  input  1  clock; all state updates on rising edge.
- iRst  input  1  synchronous, active-high reset.
- iData  input  WIDTH  input word.
- iS1  input  1  destination select, MSB.
- iS0  input  1  destination select, LSB.
- iValid  input  1  iData/iS1/iS0 valid.
- oReady  output  1  block can accept a word this cycle.
- oZ0, oZ1, oZ2, oZ3  output  WIDTH each  channel data.
- oValid0, oValid1, oValid2, oValid3  output  1 each  channel word valid.
- iReady0, iReady1, iReady2, iReady3  input  1 each  channel consumer ready.
- oCount0, oCount1, oCount2, oCount3  output  CNT_W each  words delivered per channel.
- oBusy  output  1  FIFO non-empty.

Behaviour:
- Storage
  - 2-entry FIFO; each entry holds {sel[1:0], data[WIDTH-1:0]}.
  - State: rd pointer (1 bit), wr pointer (1 bit), occupancy (0..2).
- Push
  - Occurs when iValid && oReady.
  - Captures {iS1,iS0,iData} at that edge.
- oReady
  - oReady = (occupancy != 2) && !iRst.
  - Combinational from registered state; never depends on iReadyN, so there is no input-to-output ready path.
- Head presentation
  - When occupancy > 0, head entry drives channel N = head.sel.
  - oValidN = 1 only for that channel; the other three oValid are 0.
  - oZN = head.data on the selected channel; unselected oZ are driven 0.
- Pop
  - Occurs when oValid[head.sel] && iReady[head.sel] at a rising edge.
  - At the same edge, oCount[head.sel] increments.
- Latency
  - A word pushed into an empty FIFO at edge k is visible on its channel from edge k (registered output after k) onward.
  - Minimum 1 cycle from input handshake to output valid. No combinational bypass.
- Throughput
  - 1 word/cycle sustained when the destination is continuously ready.
- Simultaneous push and pop
  - occupancy 1: both occur; occupancy stays 1; the new word becomes head after the pop.
  - occupancy 2: push is blocked because oReady = 0; pop proceeds.
  - occupancy 0: no pop possible (nothing is valid).
- Ordering
  - Strict FIFO order across all channels.
  - A stalled head blocks later words bound for other channels (head-of-line blocking by design).
- Valid stability
  - Once oValidN is asserted, oValidN and oZN hold stable until popped. Only reset may drop them.
- Counters
  - CNT_W-bit unsigned; wrap from 2^CNT_W-1 to 0; no saturation.
- oBusy = (occupancy != 0).
- Reset (iRst = 1 at an edge)
  - Occupancy, pointers and all counters go to 0.
  - All oValid, oZ, oCount and oBusy read 0; oReady reads 0 while iRst is high.
  - Reset mid-transfer discards stored words; nothing is delivered afterward.
  - Push and pop are ignored in the reset cycle.
- Select values are 2 bits, so no invalid encoding exists.

Test Plan:
- Reset → all oValid=0, oZ=0, oCount=0, oBusy=0, oReady=0 during iRst; after iRst drops, oReady=1.
- Push data 0x1111_1111 with {iS1,iS0}=2'b10, iReady2=1 → next cycle oValid2=1, oZ2=0x1111_1111, other oValid=0; after pop oCount2=1, oBusy=0.
- Backpressure, iReady0..3=0: push 0xA (sel 0), 0xB (sel 3), attempt 0xC → oReady=0 after 2nd push; 0xC not accepted; oValid0=1 with oZ0=0xA stable over 5 cycles.
- Head-of-line case: sel0 word then sel1 word, iReady1=1, iReady0=0 → oValid1 stays 0; raise iReady0 → 0xA delivered on ch0, then 0xB on ch1 next cycle.
- Streaming: 300 words to channel 3 with iReady3=1, iValid=1 every cycle → 1 word/cycle, oCount3 = 300 mod 256 = 44, data in order.
- Assert iRst for 1 cycle with occupancy 2 → next cycle occupancy 0, no oValid, counters 0; a following push delivers normally.
